// File: rtl/orange_zone_classifier.sv
// orange_zone_classifier: per-frame orange hit histogram over horizontal zones, publishes dominant zone
module orange_zone_classifier #(
    parameter int H_PIXELS   = 320,
    parameter int N_ZONES    = 4,
    parameter int LINE_START = 0,
    parameter int LINE_END   = 239,
    parameter int CNT_W      = 17,
    parameter int MIN_PIXELS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       HREF,
    input  logic                       VSYNC,
    input  logic                       is_orange,
    output logic                       orange_detected,
    output logic [$clog2(N_ZONES)-1:0] zone_idx,
    output logic [CNT_W-1:0]           zone_count,
    output logic                       result_valid,
    output logic                       sat_flag
);
    localparam int ZONE_W = H_PIXELS / N_ZONES;
    localparam int ZI_W   = $clog2(N_ZONES);
    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(LINE_END + 2);
    localparam logic [COL_W-1:0]  H_MAX   = COL_W'(H_PIXELS);
    localparam logic [COL_W-1:0]  ZW      = COL_W'(ZONE_W);
    localparam logic [LINE_W-1:0] L_START = LINE_W'(LINE_START);
    localparam logic [LINE_W-1:0] L_SPAN  = LINE_W'(LINE_END - LINE_START);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  MIN_P   = CNT_W'(MIN_PIXELS);
    localparam logic [ZI_W-1:0]   LAST_Z  = ZI_W'(N_ZONES - 1);

    typedef enum logic [1:0] {SYNC, ACCUM, SCAN, PUBLISH} state_t;

    state_t             state;
    logic               vsync_q, href_q, sat;
    logic [COL_W-1:0]   col;
    logic [LINE_W-1:0]  line;
    logic [CNT_W-1:0]   acc [N_ZONES];
    logic [CNT_W-1:0]   best;
    logic [ZI_W-1:0]    best_idx, scan_idx;

    logic               vs_rise, href_fall, hit, gt;
    logic [ZI_W-1:0]    zsel, nidx;
    logic [CNT_W-1:0]   nbest;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign href_fall = ~HREF & href_q;
    // Window test by unsigned offset: lines before LINE_START wrap to large values
    assign hit       = HREF & is_orange & (col < H_MAX) & ((line - L_START) <= L_SPAN);
    assign zsel      = ZI_W'(col / ZW);
    assign gt        = acc[scan_idx] > best;
    assign nbest     = gt ? acc[scan_idx] : best;
    assign nidx      = gt ? scan_idx : best_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            col     <= '0;
            line    <= '0;
        end else begin
            vsync_q <= VSYNC;
            href_q  <= HREF;
            col     <= HREF ? ((col == H_MAX) ? col : col + 1'b1) : '0;
            if (vs_rise)
                line <= '0;
            else if (href_fall && line != '1)
                line <= line + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SYNC;
            for (int i = 0; i < N_ZONES; i++) acc[i] <= '0;
            sat             <= 1'b0;
            best            <= '0;
            best_idx        <= '0;
            scan_idx        <= '0;
            orange_detected <= 1'b0;
            zone_idx        <= '0;
            zone_count      <= '0;
            result_valid    <= 1'b0;
            sat_flag        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                SYNC: if (vs_rise) begin
                    for (int i = 0; i < N_ZONES; i++) acc[i] <= '0;
                    sat   <= 1'b0;
                    state <= ACCUM;
                end
                ACCUM: if (vs_rise) begin
                    scan_idx <= '0;
                    best     <= '0;
                    best_idx <= '0;
                    state    <= SCAN;
                end else if (hit) begin
                    if (acc[zsel] == CNT_MAX)
                        sat <= 1'b1;
                    else
                        acc[zsel] <= acc[zsel] + 1'b1;
                end
                SCAN: begin
                    best     <= nbest;
                    best_idx <= nidx;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == LAST_Z) begin
                        orange_detected <= nbest >= MIN_P;
                        zone_idx        <= nidx;
                        zone_count      <= nbest;
                        sat_flag        <= sat;
                        result_valid    <= 1'b1;
                        state           <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    for (int i = 0; i < N_ZONES; i++) acc[i] <= '0;
                    sat   <= 1'b0;
                    state <= ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_orange_zone_classifier.sv
// tb_orange_zone_classifier: scoreboard bench on a scaled-down geometry (32 px, 4 zones, lines 2..9, 5-bit counts)
module tb_orange_zone_classifier;
    localparam int H = 32, NZ = 4, LS = 2, LE = 9, CW = 5, MINP = 6;
    localparam int ZW = H / NZ, CMAX = (1 << CW) - 1;

    logic clk = 1'b0, reset, HREF, VSYNC, is_orange;
    logic orange_detected, result_valid, sat_flag;
    logic [$clog2(NZ)-1:0] zone_idx;
    logic [CW-1:0] zone_count;

    orange_zone_classifier #(
        .H_PIXELS(H), .N_ZONES(NZ), .LINE_START(LS), .LINE_END(LE), .CNT_W(CW), .MIN_PIXELS(MINP)
    ) dut (
        .clk(clk), .reset(reset), .HREF(HREF), .VSYNC(VSYNC), .is_orange(is_orange),
        .orange_detected(orange_detected), .zone_idx(zone_idx), .zone_count(zone_count),
        .result_valid(result_valid), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {int det; int idx; int cnt; int sat; int cyc;} exp_t;
    exp_t sbq[$];
    exp_t last_exp;
    int checks = 0, failures = 0, cyc = 0, synced = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        if (result_valid) begin
            if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("latency", cyc, e.cyc);
                chk("detected", int'(orange_detected), e.det);
                chk("zone_idx", int'(zone_idx), e.idx);
                chk("zone_count", int'(zone_count), e.cnt);
                chk("sat_flag", int'(sat_flag), e.sat);
            end
        end
    end

    function automatic bit orange_at(input int mode, input int l, input int c);
        case (mode)
            0: return 1'b1;
            1: return c >= 16 && c <= 18;
            2: return l < 5 && (c == 1 || c == 30);
            3: return l < LS || l > LE || c >= H;
            4: return c >= 8 && c <= 15;
            5: return l >= 2 && l <= 7 && c == 24;
            6: return l >= 2 && l <= 6 && c == 24;
            default: return 1'b0;
        endcase
    endfunction

    task automatic frame(input int mode, input int nlines, input int hlen, input int abort);
        int z[NZ];
        int s = 0, best = 0, bi = 0, pushed = 0;
        exp_t e;
        for (int i = 0; i < NZ; i++) z[i] = 0;
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < hlen; c++) begin
                @(posedge clk); #1;
                HREF = 1'b1;
                is_orange = orange_at(mode, l, c);
                if (is_orange && c < H && l >= LS && l <= LE) begin
                    if (z[c / ZW] == CMAX) s = 1;
                    else z[c / ZW]++;
                end
            end
            @(posedge clk); #1;
            HREF = 1'b0;
            is_orange = 1'b0;
            repeat (3) @(posedge clk);
        end
        for (int i = 0; i < NZ; i++)
            if (z[i] > best) begin
                best = z[i];
                bi = i;
            end
        @(posedge clk); #1;
        VSYNC = 1'b1;
        is_orange = 1'b1;
        if (synced) begin
            e = '{det: int'(best >= MINP), idx: bi, cnt: best, sat: s, cyc: cyc + 1 + NZ};
            sbq.push_back(e);
            last_exp = e;
            pushed = 1;
        end
        synced = 1;
        if (abort) begin
            repeat (2) @(posedge clk); #1;
            reset = 1'b1;
            VSYNC = 1'b0;
            is_orange = 1'b0;
            #1;
            chk("rst_mid_det", int'(orange_detected), 0);
            chk("rst_mid_idx", int'(zone_idx), 0);
            chk("rst_mid_cnt", int'(zone_count), 0);
            chk("rst_mid_valid", int'(result_valid), 0);
            chk("rst_mid_sat", int'(sat_flag), 0);
            if (pushed) void'(sbq.pop_back());
            synced = 0;
            repeat (2) @(posedge clk); #1;
            reset = 1'b0;
            repeat (4) @(posedge clk);
        end else begin
            @(posedge clk); #1;
            is_orange = 1'b0;
            @(posedge clk); #1;
            VSYNC = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            if (pushed) begin
                chk("hold_det", int'(orange_detected), last_exp.det);
                chk("hold_idx", int'(zone_idx), last_exp.idx);
                chk("hold_cnt", int'(zone_count), last_exp.cnt);
                chk("hold_sat", int'(sat_flag), last_exp.sat);
                chk("hold_valid", int'(result_valid), 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        HREF = 1'b0;
        VSYNC = 1'b0;
        is_orange = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_det", int'(orange_detected), 0);
        chk("rst_idx", int'(zone_idx), 0);
        chk("rst_cnt", int'(zone_count), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_sat", int'(sat_flag), 0);
        reset = 1'b0;
        frame(0, 12, H, 0);
        frame(0, 12, H, 0);
        frame(1, 12, H, 0);
        frame(2, 12, H, 0);
        frame(3, 12, H + 8, 0);
        frame(4, 12, H, 0);
        frame(5, 12, H, 0);
        frame(6, 12, H, 0);
        frame(5, 12, H, 0);
        frame(1, 12, H, 1);
        frame(1, 12, H, 0);
        frame(5, 12, H, 0);
        repeat (10) @(posedge clk);
        chk("pending", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
